mem_port: RTL and testbench

Parametrised memory-access unit for the eLC-3 datapath. It owns MAR and MDR and turns the control FSM's held MIO_EN into a request/acknowledge transaction against variable-latency memory. It returns the one-cycle ready pulse R that the LC-3 control FSM waits on, and reports a sticky timeout error. It replaces the single-cycle MIO_EN/MDR-mux memory path.

---
 rtl/mem_port.sv | 133 +++++++++++++
 tb/tb_mem_port.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port.sv
// Memory-access unit for the eLC-3 datapath: owns MAR/MDR and turns a held MIO_EN
// into a request/acknowledge transaction with a one-cycle R pulse and sticky timeout.
module mem_port #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Bus,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              MIO_EN,
    input  logic              R_W,
    input  logic              Clear_Err,
    input  logic              Mem_Ack,
    input  logic [DATA_W-1:0] Mem_RData,
    output logic [ADDR_W-1:0] MAR,
    output logic [DATA_W-1:0] MDR,
    output logic              R,
    output logic              Error,
    output logic              Mem_Req,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = LAST[CNT_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_r;
    logic                r_error;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_ack;
    logic                w_timeout;

    // An acknowledge in the final wait cycle beats the timeout.
    assign w_ack     = (r_state == S_REQ) && Mem_Ack;
    assign w_timeout = (r_state == S_REQ) && !Mem_Ack && (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_mar <= '0;
        end else if (LD_MAR) begin
            r_mar <= Bus[ADDR_W-1:0];
        end
    end

    // Memory completion writes win over bus loads; MIO_EN blocks bus loads entirely.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_mdr <= '0;
        end else if (w_ack && !r_we) begin
            r_mdr <= Mem_RData;
        end else if (w_timeout && !r_we) begin
            r_mdr <= '1;
        end else if (LD_MDR && !MIO_EN) begin
            r_mdr <= Bus;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_r     <= 1'b0;
            r_error <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_timeout) begin
                r_error <= 1'b1;
            end else if (Clear_Err) begin
                r_error <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_r <= 1'b0;
                    if (MIO_EN) begin
                        r_addr  <= r_mar;
                        r_wdata <= r_mdr;
                        r_we    <= R_W;
                        r_cnt   <= '0;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_ack || w_timeout) begin
                        r_req   <= 1'b0;
                        r_r     <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_r     <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_r     <= 1'b0;
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign MAR       = r_mar;
    assign MDR       = r_mdr;
    assign R         = r_r;
    assign Error     = r_error;
    assign Mem_Req   = r_req;
    assign Mem_We    = r_we;
    assign Mem_Addr  = r_addr;
    assign Mem_WData = r_wdata;

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: reads, wait-state writes, timeouts, races and conflicts
// checked against hand-computed values.
module tb_mem_port;

    logic        Clk;
    logic        Reset;
    logic [15:0] Bus;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        MIO_EN;
    logic        R_W;
    logic        Clear_Err;
    logic        Mem_Ack;
    logic [15:0] Mem_RData;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        R;
    logic        Error;
    logic        Mem_Req;
    logic        Mem_We;
    logic [15:0] Mem_Addr;
    logic [15:0] Mem_WData;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Bus       (Bus),
        .LD_MAR    (LD_MAR),
        .LD_MDR    (LD_MDR),
        .MIO_EN    (MIO_EN),
        .R_W       (R_W),
        .Clear_Err (Clear_Err),
        .Mem_Ack   (Mem_Ack),
        .Mem_RData (Mem_RData),
        .MAR       (MAR),
        .MDR       (MDR),
        .R         (R),
        .Error     (Error),
        .Mem_Req   (Mem_Req),
        .Mem_We    (Mem_We),
        .Mem_Addr  (Mem_Addr),
        .Mem_WData (Mem_WData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_mar(input logic [15:0] v);
        Bus = v; LD_MAR = 1'b1;
        step();
        LD_MAR = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        Bus = v; LD_MDR = 1'b1;
        step();
        LD_MDR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        Reset = 1'b1; Bus = '0; LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; R_W = 0;
        Clear_Err = 0; Mem_Ack = 0; Mem_RData = '0;
        step(); step();
        Reset = 1'b0;
        step();

        // Reset state
        check("rst_mar", MAR, 16'h0);
        check("rst_mdr", MDR, 16'h0);
        check("rst_r", R, 0);
        check("rst_err", Error, 0);
        check("rst_req", Mem_Req, 0);
        check("rst_we", Mem_We, 0);
        check("rst_addr", Mem_Addr, 16'h0);
        check("rst_wdata", Mem_WData, 16'h0);

        // Zero-wait read
        load_mar(16'h3000);
        MIO_EN = 1; R_W = 0;
        step();                                   // cycle 1
        check("zw_req_c1", Mem_Req, 1);
        check("zw_addr", Mem_Addr, 16'h3000);
        check("zw_we", Mem_We, 0);
        check("zw_r_c1", R, 0);
        Mem_Ack = 1; Mem_RData = 16'hBEEF;
        step();                                   // cycle 2
        check("zw_r_c2", R, 1);
        check("zw_mdr", MDR, 16'hBEEF);
        check("zw_err", Error, 0);
        check("zw_req_c2", Mem_Req, 0);
        Mem_Ack = 0;
        step();                                   // cycle 3
        MIO_EN = 0;
        check("zw_r_c3", R, 0);

        // Mem_Ack outside REQ is ignored
        Mem_Ack = 1; Mem_RData = 16'h0BAD;
        step(); step();
        check("idle_ack_r", R, 0);
        check("idle_ack_mdr", MDR, 16'hBEEF);
        Mem_Ack = 0;

        // Wait-state write, ack sampled at edge 4
        load_mdr(16'h1234);
        load_mar(16'h3001);
        MIO_EN = 1; R_W = 1;
        step();                                   // cycle 1
        R_W = 0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("wr_req_c%0d", i), Mem_Req, 1);
            check($sformatf("wr_we_c%0d", i), Mem_We, 1);
            check($sformatf("wr_wdata_c%0d", i), Mem_WData, 16'h1234);
            check($sformatf("wr_r_c%0d", i), R, 0);
            if (i == 4) begin
                Mem_Ack = 1; Mem_RData = 16'hDEAD;
            end
            step();
        end
        check("wr_r_c5", R, 1);
        check("wr_addr", Mem_Addr, 16'h3001);
        check("wr_mdr", MDR, 16'h1234);
        Mem_Ack = 0;
        step();
        MIO_EN = 0;
        check("wr_r_c6", R, 0);

        // Timeout read
        load_mar(16'h3002);
        MIO_EN = 1; R_W = 0;
        step();                                   // cycle 1
        cnt = 0;
        while (Mem_Req === 1'b1 && cnt < 40) begin
            cnt++;
            check("to_r_low", R, 0);
            step();
        end
        check("to_req_cycles", cnt, 15);
        check("to_r", R, 1);
        check("to_err", Error, 1);
        check("to_mdr", MDR, 16'hFFFF);
        step();
        MIO_EN = 0;
        step(); step(); step();
        check("to_err_sticky", Error, 1);
        Clear_Err = 1;
        step();
        Clear_Err = 0;
        check("to_err_clr", Error, 0);

        // Timeout with Clear_Err in the timeout cycle
        MIO_EN = 1;
        step();                                   // cycle 1
        for (int i = 1; i < 15; i++) step();      // cycle 15
        check("toc_req_c15", Mem_Req, 1);
        Clear_Err = 1;
        step();                                   // cycle 16
        Clear_Err = 0;
        check("toc_r", R, 1);
        check("toc_err", Error, 1);
        step();
        MIO_EN = 0;
        Clear_Err = 1;
        step();
        Clear_Err = 0;
        check("toc_err_clr", Error, 0);

        // Ack in the timeout cycle
        load_mar(16'h3004);
        MIO_EN = 1; R_W = 0;
        step();                                   // cycle 1
        for (int i = 1; i < 15; i++) step();      // cycle 15
        check("race_req_c15", Mem_Req, 1);
        Mem_Ack = 1; Mem_RData = 16'h5A5A;
        step();                                   // cycle 16
        Mem_Ack = 0;
        check("race_r", R, 1);
        check("race_err", Error, 0);
        check("race_mdr", MDR, 16'h5A5A);
        step();
        MIO_EN = 0;

        // Conflicts: LD_MAR during REQ, LD_MDR with read ack, MIO_EN held through DONE
        load_mar(16'h3003);
        MIO_EN = 1; R_W = 0;
        step();                                   // cycle 1
        Bus = 16'h4000; LD_MAR = 1;
        step();                                   // cycle 2
        LD_MAR = 0;
        check("cf_mar", MAR, 16'h4000);
        check("cf_addr", Mem_Addr, 16'h3003);
        Mem_Ack = 1; Mem_RData = 16'h1111; LD_MDR = 1; Bus = 16'h2222;
        step();                                   // cycle 3
        Mem_Ack = 0; LD_MDR = 0;
        check("cf_r", R, 1);
        check("cf_mdr_ack", MDR, 16'h1111);
        step();                                   // IDLE, MIO_EN still high
        check("cf_idle_r", R, 0);
        check("cf_idle_req", Mem_Req, 0);
        step();                                   // second access cycle 1
        check("cf2_req", Mem_Req, 1);
        check("cf2_addr", Mem_Addr, 16'h4000);
        LD_MDR = 1; Bus = 16'h9999;
        step();
        LD_MDR = 0;
        check("cf2_mdr_blocked", MDR, 16'h1111);
        Mem_Ack = 1; Mem_RData = 16'h7777;
        step();
        Mem_Ack = 0;
        check("cf2_r", R, 1);
        check("cf2_mdr", MDR, 16'h7777);
        step();
        MIO_EN = 0;

        // Reset mid-REQ
        load_mar(16'h3005);
        MIO_EN = 1;
        step(); step();                           // cycle 2, in REQ
        check("mr_req_before", Mem_Req, 1);
        #2 Reset = 1'b1;
        #1;
        check("mr_req", Mem_Req, 0);
        check("mr_r", R, 0);
        check("mr_mar", MAR, 16'h0);
        check("mr_mdr", MDR, 16'h0);
        check("mr_addr", Mem_Addr, 16'h0);
        check("mr_err", Error, 0);
        MIO_EN = 0;
        step();
        #2 Reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (R === 1'b1) cnt++;
        end
        check("mr_no_r", cnt, 0);
        check("mr_req_after", Mem_Req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
